pp_mul_share_arbiter: RTL and testbench

//  Shares one pipelined unsigned 12x12->24 multiplier among NUM_REQ requesters
//  in the pre-processing pipeline. Arbitrates requests with a round-robin

---
 rtl/pp_mul_share_arbiter.sv | 106 ++++++++++
 tb/tb_pp_mul_share_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_mul_share_arbiter.sv
// Round-robin arbiter sharing one pipelined 12x12->24 multiplier among NUM_REQ requesters.
// Optional PP_MUL_ARB_PRIO_EN: requester 0 gets strict priority over the round-robin group.
module pp_mul_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*12-1:0] req_a,
  input  logic [NUM_REQ*12-1:0] req_b,
  output logic                  mul_ce,
  output logic [11:0]           mul_din0,
  output logic [11:0]           mul_din1,
  input  logic [23:0]           mul_dout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [23:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id
);

  logic [MUL_LAT:1] vld;
  logic [ID_W-1:0]  tag [1:MUL_LAT];
  logic [ID_W-1:0]  rr_ptr;
  logic             stall;
  logic             grant_any;
  logic             upd_ptr;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W:0]    cand;
  logic [NUM_REQ-1:0] valid_sh;
  int unsigned      sel_sh;

  assign stall  = vld[MUL_LAT] & ~rsp_ready;
  assign mul_ce = ~stall;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_ptr;
    upd_ptr   = 1'b0;
    cand      = '0;
    valid_sh  = '0;
    if (!stall) begin
      // scan from rr_ptr upward, wrapping modulo NUM_REQ
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (cand >= (ID_W+1)'(NUM_REQ))
          cand = cand - (ID_W+1)'(NUM_REQ);
        valid_sh = req_valid >> cand;
        if (!grant_any && valid_sh[0]) begin
          grant_any = 1'b1;
          grant_idx = cand[ID_W-1:0];
        end
      end
      upd_ptr = grant_any;
`ifdef PP_MUL_ARB_PRIO_EN
      // requester 0 overrides the rotation and leaves rr_ptr untouched
      if (req_valid[0]) begin
        grant_any = 1'b1;
        grant_idx = '0;
        upd_ptr   = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_any)
      req_ready = NUM_REQ'(1) << grant_idx;
  end

  assign sel_sh   = 32'(grant_idx) * 12;
  assign mul_din0 = 12'(req_a >> sel_sh);
  assign mul_din1 = 12'(req_b >> sel_sh);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld    <= '0;
      rr_ptr <= '0;
      for (int unsigned k = 1; k <= MUL_LAT; k++)
        tag[k] <= '0;
    end else begin
      if (mul_ce) begin
        vld[1] <= grant_any;
        tag[1] <= grant_idx;
        for (int unsigned k = 2; k <= MUL_LAT; k++) begin
          vld[k] <= vld[k-1];
          tag[k] <= tag[k-1];
        end
      end
      if (upd_ptr) begin
        if (grant_idx == ID_W'(NUM_REQ-1))
          rr_ptr <= '0;
        else
          rr_ptr <= grant_idx + 1'b1;
      end
    end
  end

  assign rsp_valid = vld[MUL_LAT];
  assign rsp_data  = mul_dout;
  assign rsp_id    = tag[MUL_LAT];

endmodule

// File: tb/tb_pp_mul_share_arbiter.sv
// Directed bench for pp_mul_share_arbiter with a 3-stage clock-enabled multiplier model.
module tb_pp_mul_share_arbiter;

`ifdef PP_MUL_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [47:0] req_a;
  logic [47:0] req_b;
  logic        mul_ce;
  logic [11:0] mul_din0;
  logic [11:0] mul_din1;
  logic [23:0] mul_dout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [23:0] rsp_data;
  logic [1:0]  rsp_id;

  int errors = 0;
  int checks = 0;

  pp_mul_share_arbiter #(.NUM_REQ(4), .ID_W(2), .MUL_LAT(3)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 ap_clk = ~ap_clk;

  // external multiplier: operand regs -> product -> output, frozen when ce=0
  logic [11:0] m_a, m_b;
  logic [23:0] m_p, m_o;
  always @(posedge ap_clk) begin
    if (mul_ce) begin
      m_a <= mul_din0;
      m_b <= mul_din1;
      m_p <= 24'(m_a) * 24'(m_b);
      m_o <= m_p;
    end
  end
  assign mul_dout = m_o;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    ap_rst_n  = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    next_cycle();
    next_cycle();
    ap_rst_n = 1'b1;
  endtask

  task automatic set_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[i*12 +: 12] = 12'(i + 1);
      req_b[i*12 +: 12] = 12'd2;
    end
  endtask

  initial begin
    int g;
    int id;
    req_a = '0;
    req_b = '0;
    do_reset();
    ap_rst_n = 1'b0;
    settle();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mul_ce", mul_ce, 1);
    ap_rst_n = 1'b1;
    next_cycle();

    // max operands, single request, latency 3
    req_a[11:0] = 12'hFFF;
    req_b[11:0] = 12'hFFF;
    req_valid   = 4'b0001;
    settle();
    chk("t1_ready", req_ready, 4'b0001);
    chk("t1_din0", mul_din0, 12'hFFF);
    next_cycle();
    req_valid = '0;
    settle();
    chk("t1_lat1", rsp_valid, 0);
    next_cycle();
    chk("t1_lat2", rsp_valid, 0);
    next_cycle();
    settle();
    chk("t1_valid", rsp_valid, 1);
    chk("t1_data", rsp_data, 24'hFFE001);
    chk("t1_id", rsp_id, 0);
    next_cycle();
    chk("t1_drained", rsp_valid, 0);

    // all requesters continuously valid, full throughput
    do_reset();
    set_ops();
    for (int c = 0; c < 11; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      settle();
      if (c < 8) begin
        g = PRIO ? 0 : c % 4;
        chk("t2_grant", req_ready, 4'b0001 << g);
      end
      if (c >= 3) begin
        id = PRIO ? 0 : (c - 3) % 4;
        chk("t2_valid", rsp_valid, 1);
        chk("t2_data", rsp_data, 24'(2 * (id + 1)));
        chk("t2_id", rsp_id, id);
      end
      next_cycle();
    end

    // response stall freezes pipe and blocks grants
    for (int c = 0; c < 12; c++) begin
      if (c < 3) begin
        req_valid = 4'hF; rsp_ready = 1'b1;
        settle();
        g = PRIO ? 0 : c;
        chk("t3_grant", req_ready, 4'b0001 << g);
      end else if (c < 8) begin
        req_valid = 4'hF; rsp_ready = 1'b0;
        settle();
        chk("t3_ce", mul_ce, 0);
        chk("t3_ready", req_ready, 0);
        chk("t3_valid", rsp_valid, 1);
        chk("t3_data", rsp_data, 24'd2);
        chk("t3_id", rsp_id, 0);
      end else if (c < 11) begin
        req_valid = 4'h0; rsp_ready = 1'b1;
        settle();
        id = PRIO ? 0 : c - 8;
        chk("t3_out_valid", rsp_valid, 1);
        chk("t3_out_data", rsp_data, 24'(2 * (id + 1)));
        chk("t3_out_id", rsp_id, id);
      end else begin
        settle();
        chk("t3_empty", rsp_valid, 0);
      end
      next_cycle();
    end

    // wrap-around: req2 alone, then req1 and req3 together
    req_valid = 4'b0100;
    settle();
    chk("t4_g2", req_ready, 4'b0100);
    next_cycle();
    req_valid = 4'b1010;
    settle();
    chk("t4_g3", req_ready, 4'b1000);
    next_cycle();
    settle();
    chk("t4_g1", req_ready, 4'b0010);
    next_cycle();
    req_valid = '0;
    settle();
    chk("t4_id_a", rsp_id, 2);
    chk("t4_data_a", rsp_data, 24'd6);
    next_cycle();
    chk("t4_id_b", rsp_id, 3);
    chk("t4_data_b", rsp_data, 24'd8);
    next_cycle();
    chk("t4_id_c", rsp_id, 1);
    chk("t4_data_c", rsp_data, 24'd4);
    next_cycle();
    chk("t4_empty", rsp_valid, 0);

    // reset with three operations in flight
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'hF;
      settle();
      g = PRIO ? 0 : (c + 2) % 4;
      chk("t5_grant", req_ready, 4'b0001 << g);
      next_cycle();
    end
    req_valid = '0;
    settle();
    chk("t5_pre_valid", rsp_valid, 1);
    ap_rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", rsp_valid, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_ce", mul_ce, 1);
    next_cycle();
    next_cycle();
    ap_rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("t5_no_stale", rsp_valid, 0);
      next_cycle();
    end
    req_valid = 4'b1001;
    settle();
    chk("t5_ptr0", req_ready, 4'b0001);
    next_cycle();
    req_valid = '0;
    next_cycle();
    next_cycle();
    settle();
    chk("t5_rsp_valid", rsp_valid, 1);
    chk("t5_rsp_data", rsp_data, 24'd2);
    next_cycle();

    // req0 and req1 contending
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req_valid = 4'b0011;
      settle();
      g = (PRIO || (c % 2 == 0)) ? 0 : 1;
      chk("t6_grant", req_ready, 4'b0001 << g);
      next_cycle();
    end
    req_valid = 4'b0010;
    settle();
    chk("t6_req1", req_ready, 4'b0010);
    next_cycle();
    req_valid = '0;
    for (int c = 0; c < 4; c++) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
